// File: rtl/apb_xbar_rr_pkg.sv
// Shared FSM encoding, index-width macro and the default MMU address map for apb_xbar_rr.
`ifndef APB_XBAR_RR_CLOG2
`define APB_XBAR_RR_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

package apb_xbar_rr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  // MMU map: four 4 KiB windows from 0x0000, slice i is slave i.
  localparam int MMU_SLAVES = 4;
  localparam int MMU_AW     = 16;
  localparam logic [MMU_SLAVES*MMU_AW-1:0] MMU_BASE =
    {16'h3000, 16'h2000, 16'h1000, 16'h0000};
  localparam logic [MMU_SLAVES*MMU_AW-1:0] MMU_MASK =
    {16'hF000, 16'hF000, 16'hF000, 16'hF000};

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester after last-granted, registers the winner.
// The pointer only moves on a completed transfer (adv_i), so aborted grants keep their priority.
module rr_arbiter
  import apb_xbar_rr_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = `APB_XBAR_RR_CLOG2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  input  logic          load_i,
  input  logic          adv_i,
  input  logic          clr_i,
  output logic [IW-1:0] pick_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          gnt_vld_o
);

  logic [IW-1:0] last_q;
  logic [IW-1:0] gnt_q;
  logic          vld_q;

  // Descending scan so the requester closest after last_q is written last.
  always_comb begin
    pick_o = last_q;
    for (int k = N; k >= 1; k--) begin
      if (req_i[IW'((int'(last_q) + k) % N)]) begin
        pick_o = IW'((int'(last_q) + k) % N);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= IW'(N - 1);
      gnt_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      if (load_i && |req_i) begin
        gnt_q <= pick_o;
        vld_q <= 1'b1;
      end else if (clr_i) begin
        vld_q <= 1'b0;
      end
      if (adv_i) begin
        last_q <= gnt_q;
      end
    end
  end

  assign gnt_idx_o = gnt_q;
  assign gnt_vld_o = vld_q;

endmodule

// File: rtl/apb_xbar_rr.sv
// N-master / M-slave APB crossbar over one round-robin path; IDLE->SETUP->ACCESS per transfer.
// Define APB_XBAR_TIMEOUT_EN to bound ACCESS to TIMEOUT_CYCLES wait states with a forced PSLVERR.
module apb_xbar_rr
  import apb_xbar_rr_pkg::*;
#(
  parameter int MASTER_PORTS   = 2,
  parameter int SLAVE_PORTS    = 4,
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter logic [SLAVE_PORTS*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [SLAVE_PORTS*ADDR_WIDTH-1:0] SLAVE_MASK = '0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [MASTER_PORTS*ADDR_WIDTH-1:0] S_PADDR,
  input  logic [MASTER_PORTS-1:0]            S_PWRITE,
  input  logic [MASTER_PORTS-1:0]            S_PSEL,
  input  logic [MASTER_PORTS-1:0]            S_PENABLE,
  input  logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PWDATA,
  output logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PRDATA,
  output logic [MASTER_PORTS-1:0]            S_PREADY,
  output logic [MASTER_PORTS-1:0]            S_PSLVERR,
  output logic [ADDR_WIDTH-1:0]              M_PADDR,
  output logic                               M_PWRITE,
  output logic [SLAVE_PORTS-1:0]             M_PSEL,
  output logic                               M_PENABLE,
  output logic [DATA_WIDTH-1:0]              M_PWDATA,
  input  logic [SLAVE_PORTS*DATA_WIDTH-1:0]  M_PRDATA,
  input  logic [SLAVE_PORTS-1:0]             M_PREADY,
  input  logic [SLAVE_PORTS-1:0]             M_PSLVERR
);

  localparam int IW = `APB_XBAR_RR_CLOG2(MASTER_PORTS);
  localparam int SW = `APB_XBAR_RR_CLOG2(SLAVE_PORTS);

  state_e                  state_q, state_d;
  logic [IW-1:0]           pick, gnt;
  logic                    gnt_vld;
  logic [ADDR_WIDTH-1:0]   pick_addr, addr_q;
  logic                    write_q;
  logic [DATA_WIDTH-1:0]   wdata_q, resp_data;
  logic [SLAVE_PORTS-1:0]  sel_q, sel_d;
  logic [SW-1:0]           slv_q, slv_d;
  logic                    unmap_q, unmap_d;
  logic                    done, abort, resp_err, timeout;
  logic                    unused_penable;

  // PENABLE from the masters carries no information the bridge needs.
  assign unused_penable = ^S_PENABLE;

  rr_arbiter #(.N(MASTER_PORTS)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (S_PSEL),
    .load_i    (state_q == IDLE),
    .adv_i     (done),
    .clr_i     (done | abort),
    .pick_o    (pick),
    .gnt_idx_o (gnt),
    .gnt_vld_o (gnt_vld)
  );

  assign pick_addr = S_PADDR[pick*ADDR_WIDTH +: ADDR_WIDTH];

  // Descending scan: the lowest-index hit is written last and wins.
  always_comb begin
    unmap_d = 1'b1;
    slv_d   = '0;
    sel_d   = '0;
    for (int i = SLAVE_PORTS - 1; i >= 0; i--) begin
      if ((pick_addr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          (SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        unmap_d = 1'b0;
        slv_d   = SW'(i);
      end
    end
    if (!unmap_d) sel_d[slv_d] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      sel_q   <= '0;
      slv_q   <= '0;
      unmap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && |S_PSEL) begin
        addr_q  <= pick_addr;
        write_q <= S_PWRITE[pick];
        wdata_q <= S_PWDATA[pick*DATA_WIDTH +: DATA_WIDTH];
        sel_q   <= sel_d;
        slv_q   <= slv_d;
        unmap_q <= unmap_d;
      end
    end
  end

`ifdef APB_XBAR_TIMEOUT_EN
  localparam int CW = `APB_XBAR_RR_CLOG2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || state_q != ACCESS) begin
      tmo_cnt_q <= '0;
    end else if (!M_PREADY[slv_q] && !timeout) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  assign timeout = (tmo_cnt_q == CW'(TIMEOUT_CYCLES));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    done      = 1'b0;
    abort     = 1'b0;
    resp_err  = 1'b0;
    resp_data = '0;
    S_PREADY  = '0;
    S_PSLVERR = '0;
    S_PRDATA  = '0;
    case (state_q)
      IDLE: begin
        if (|S_PSEL) state_d = SETUP;
      end
      SETUP: begin
        if (S_PSEL[gnt]) begin
          state_d = ACCESS;
        end else begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (!S_PSEL[gnt]) begin
          abort = 1'b1;
        end else if (unmap_q) begin
          done     = 1'b1;
          resp_err = 1'b1;
        end else if (M_PREADY[slv_q]) begin
          done      = 1'b1;
          resp_err  = M_PSLVERR[slv_q];
          resp_data = M_PRDATA[slv_q*DATA_WIDTH +: DATA_WIDTH];
        end else if (timeout) begin
          done     = 1'b1;
          resp_err = 1'b1;
        end
        if (done || abort) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A reset in the completing cycle suppresses the response.
    if (done && gnt_vld && !rst) begin
      S_PREADY[gnt]                         = 1'b1;
      S_PSLVERR[gnt]                        = resp_err;
      S_PRDATA[gnt*DATA_WIDTH +: DATA_WIDTH] = resp_data;
    end
  end

  assign M_PADDR   = (state_q != IDLE) ? addr_q  : '0;
  assign M_PWRITE  = (state_q != IDLE) ? write_q : 1'b0;
  assign M_PWDATA  = (state_q != IDLE) ? wdata_q : '0;
  assign M_PSEL    = (state_q != IDLE) ? sel_q   : '0;
  assign M_PENABLE = (state_q == ACCESS);

endmodule

// File: tb/tb_apb_xbar_rr.sv
// Scoreboard bench for apb_xbar_rr: two masters, four slaves on the MMU map, optional timeout case.
module tb_apb_xbar_rr;
  import apb_xbar_rr_pkg::*;

  localparam int MP = 2;
  localparam int SP = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  typedef struct {
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] wd;
    bit            tmo;
  } cmd_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] wd;
    logic [SP-1:0] psel;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [MP*AW-1:0] S_PADDR   = '0;
  logic [MP-1:0]    S_PWRITE  = '0;
  logic [MP-1:0]    S_PSEL    = '0;
  logic [MP-1:0]    S_PENABLE = '0;
  logic [MP*DW-1:0] S_PWDATA  = '0;
  logic [MP*DW-1:0] S_PRDATA;
  logic [MP-1:0]    S_PREADY;
  logic [MP-1:0]    S_PSLVERR;
  logic [AW-1:0]    M_PADDR;
  logic             M_PWRITE;
  logic [SP-1:0]    M_PSEL;
  logic             M_PENABLE;
  logic [DW-1:0]    M_PWDATA;
  logic [SP*DW-1:0] M_PRDATA;
  logic [SP-1:0]    M_PREADY;
  logic [SP-1:0]    M_PSLVERR;

  logic [DW-1:0] rd_val [SP];
  logic          slverr [SP];
  int            delay  [SP];
  int            acc_cnt[SP];

  cmd_t cmd_q [MP][$];
  exp_t exp_q [MP][$];
  int   order_q[$];
  bit   active [MP];
  bit   done   [MP];
  bit   kill;

  int n_vec = 0;
  int n_err = 0;

  apb_xbar_rr #(
    .MASTER_PORTS  (MP),
    .SLAVE_PORTS   (SP),
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .SLAVE_BASE    (MMU_BASE),
    .SLAVE_MASK    (MMU_MASK),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .S_PADDR  (S_PADDR),
    .S_PWRITE (S_PWRITE),
    .S_PSEL   (S_PSEL),
    .S_PENABLE(S_PENABLE),
    .S_PWDATA (S_PWDATA),
    .S_PRDATA (S_PRDATA),
    .S_PREADY (S_PREADY),
    .S_PSLVERR(S_PSLVERR),
    .M_PADDR  (M_PADDR),
    .M_PWRITE (M_PWRITE),
    .M_PSEL   (M_PSEL),
    .M_PENABLE(M_PENABLE),
    .M_PWDATA (M_PWDATA),
    .M_PRDATA (M_PRDATA),
    .M_PREADY (M_PREADY),
    .M_PSLVERR(M_PSLVERR)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference decode of the MMU map: 4 KiB windows, slaves 0..3 at 0x0000..0x3FFF.
  function automatic int slv_of(input logic [AW-1:0] a);
    if (a[15:12] < 4'd4) return int'(a[15:12]);
    return -1;
  endfunction

  task automatic push_cmd(input int m, input logic [AW-1:0] a, input logic w,
                          input logic [DW-1:0] d, input bit t);
    cmd_t c;
    c.addr = a; c.wr = w; c.wd = d; c.tmo = t;
    cmd_q[m].push_back(c);
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int i = 0; i < 200 && !idle; i++) begin
      @(negedge clk);
      idle = !active[0] && !active[1] && cmd_q[0].size() == 0 && cmd_q[1].size() == 0;
    end
    chk_eq("drain", 32'(idle), 1);
  endtask

  always_comb begin
    M_PREADY  = '0;
    M_PRDATA  = '0;
    M_PSLVERR = '0;
    for (int s = 0; s < SP; s++) begin
      M_PREADY[s]          = M_PSEL[s] & M_PENABLE & (acc_cnt[s] > delay[s]);
      M_PRDATA[s*DW +: DW] = rd_val[s];
      M_PSLVERR[s]         = slverr[s];
    end
  end

  // Masters and slave wait-state counters advance just after each rising edge.
  initial begin
    cmd_t c;
    exp_t e;
    int   s;
    for (int i = 0; i < SP; i++) acc_cnt[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int m = 0; m < MP; m++) begin
        if (kill) begin
          S_PSEL[m] = 1'b0; S_PENABLE[m] = 1'b0;
          active[m] = 1'b0; done[m] = 1'b0;
          cmd_q[m].delete(); exp_q[m].delete();
        end else begin
          if (done[m]) begin
            active[m] = 1'b0; done[m] = 1'b0;
            S_PSEL[m] = 1'b0; S_PENABLE[m] = 1'b0;
          end
          if (!active[m] && cmd_q[m].size() > 0) begin
            c = cmd_q[m].pop_front();
            S_PADDR[m*AW +: AW]  = c.addr;
            S_PWRITE[m]          = c.wr;
            S_PWDATA[m*DW +: DW] = c.wd;
            S_PSEL[m]            = 1'b1;
            S_PENABLE[m]         = 1'b0;
            active[m]            = 1'b1;
            s = slv_of(c.addr);
            e.addr = c.addr; e.wr = c.wr; e.wd = c.wd;
            e.psel = '0; e.rdata = '0; e.err = 1'b1;
            if (s >= 0) begin
              e.psel = SP'(1 << s);
              if (!c.tmo) begin
                e.rdata = rd_val[s];
                e.err   = slverr[s];
              end
            end
            exp_q[m].push_back(e);
          end else if (active[m]) begin
            S_PENABLE[m] = 1'b1;
          end
        end
      end
      kill = 1'b0;
      for (int i = 0; i < SP; i++) begin
        acc_cnt[i] = (M_PSEL[i] && M_PENABLE) ? acc_cnt[i] + 1 : 0;
      end
    end
  end

  // Response monitor: pops the scoreboard on every S_PREADY, checks idle masters stay quiet.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int m = 0; m < MP; m++) begin
        if (S_PREADY[m]) begin
          if (exp_q[m].size() == 0) begin
            chk_eq("spurious_pready", 32'(S_PREADY[m]), 0);
          end else begin
            e = exp_q[m].pop_front();
            chk_eq("prdata",  32'(S_PRDATA[m*DW +: DW]), 32'(e.rdata));
            chk_eq("pslverr", 32'(S_PSLVERR[m]), 32'(e.err));
            chk_eq("paddr",   32'(M_PADDR), 32'(e.addr));
            chk_eq("pwrite",  32'(M_PWRITE), 32'(e.wr));
            chk_eq("psel",    32'(M_PSEL), 32'(e.psel));
            chk_eq("penable", 32'(M_PENABLE), 1);
            if (e.wr) chk_eq("pwdata", 32'(M_PWDATA), 32'(e.wd));
            order_q.push_back(m);
            done[m] = 1'b1;
          end
        end else begin
          chk_eq("quiet_prdata",  32'(S_PRDATA[m*DW +: DW]), 0);
          chk_eq("quiet_pslverr", 32'(S_PSLVERR[m]), 0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run did not complete at %0t", $time);
    $fatal(1);
  end

  initial begin
    int  n;
    bit  found;
    rd_val[0] = 16'h1111; rd_val[1] = 16'h2222; rd_val[2] = 16'h1234; rd_val[3] = 16'h4444;
    slverr[0] = 1'b0; slverr[1] = 1'b0; slverr[2] = 1'b0; slverr[3] = 1'b1;
    for (int i = 0; i < SP; i++) delay[i] = 0;
    kill = 1'b0;
    for (int m = 0; m < MP; m++) begin active[m] = 1'b0; done[m] = 1'b0; end

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_eq("rst_m_psel",    32'(M_PSEL), 0);
    chk_eq("rst_m_penable", 32'(M_PENABLE), 0);
    chk_eq("rst_m_paddr",   32'(M_PADDR), 0);
    chk_eq("rst_m_pwdata",  32'(M_PWDATA), 0);
    chk_eq("rst_s_pready",  32'(S_PREADY), 0);
    chk_eq("rst_s_prdata",  32'(S_PRDATA), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single write, slave 1 ready at once.
    push_cmd(0, 16'h1004, 1'b1, 16'hBEEF, 1'b0);
    @(negedge clk);
    chk_eq("t1_idle_psel", 32'(M_PSEL), 0);
    @(negedge clk);
    chk_eq("t1_setup_psel",    32'(M_PSEL), 32'h2);
    chk_eq("t1_setup_penable", 32'(M_PENABLE), 0);
    chk_eq("t1_setup_pwdata",  32'(M_PWDATA), 32'hBEEF);
    @(negedge clk);
    chk_eq("t1_access_penable", 32'(M_PENABLE), 1);
    chk_eq("t1_access_pready",  32'(S_PREADY), 32'h1);
    wait_idle();

    // Both masters streaming: last grant was 0, so master 1 goes first and they alternate.
    order_q.delete();
    for (int i = 0; i < 3; i++) begin
      push_cmd(0, 16'h0010 + 16'(i), 1'b1, 16'hA000 + 16'(i), 1'b0);
      push_cmd(1, 16'h3020 + 16'(i), 1'b0, 16'h0000, 1'b0);
    end
    wait_idle();
    chk_eq("t2_count", 32'(order_q.size()), 6);
    for (int i = 0; i < order_q.size(); i++) begin
      chk_eq("t2_order", 32'(order_q[i]), (i % 2 == 0) ? 1 : 0);
    end

    // Read with four wait states: ACCESS spans five cycles.
    delay[2] = 4;
    push_cmd(1, 16'h2008, 1'b0, 16'h0000, 1'b0);
    n = 0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (M_PENABLE) n++;
      found = !active[1] && exp_q[1].size() == 0 && cmd_q[1].size() == 0;
    end
    chk_eq("t3_access_cycles", 32'(n), 5);
    delay[2] = 0;

    // Unmapped address: no slave selected, immediate error response.
    push_cmd(0, 16'h8000, 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk_eq("t4_setup_psel", 32'(M_PSEL), 0);
    @(negedge clk);
    chk_eq("t4_access_psel",    32'(M_PSEL), 0);
    chk_eq("t4_access_pready",  32'(S_PREADY), 32'h1);
    chk_eq("t4_access_pslverr", 32'(S_PSLVERR), 32'h1);
    wait_idle();

    // Reset in the middle of ACCESS, then check the pointer restarted at master 0.
    delay[1] = 10;
    push_cmd(1, 16'h1000, 1'b0, 16'h0000, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      found = M_PENABLE;
    end
    chk_eq("t5_reach_access", 32'(found), 1);
    rst  = 1'b1;
    kill = 1'b1;
    #1;
    chk_eq("t5_rst_no_pready", 32'(S_PREADY), 0);
    @(negedge clk);
    chk_eq("t5_m_psel",    32'(M_PSEL), 0);
    chk_eq("t5_m_penable", 32'(M_PENABLE), 0);
    chk_eq("t5_m_paddr",   32'(M_PADDR), 0);
    chk_eq("t5_s_pready",  32'(S_PREADY), 0);
    rst = 1'b0;
    delay[1] = 0;
    order_q.delete();
    push_cmd(1, 16'h1000, 1'b0, 16'h0000, 1'b0);
    push_cmd(0, 16'h0004, 1'b0, 16'h0000, 1'b0);
    wait_idle();
    chk_eq("t5_count", 32'(order_q.size()), 2);
    if (order_q.size() > 0) chk_eq("t5_first_grant", 32'(order_q[0]), 0);

`ifdef APB_XBAR_TIMEOUT_EN
    // Slave 2 never ready: forced error after eight waiting ACCESS cycles.
    delay[2] = 1000;
    push_cmd(0, 16'h2000, 1'b0, 16'h0000, 1'b1);
    n = 0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (M_PENABLE) n++;
      found = S_PREADY[0];
    end
    chk_eq("t6_access_cycles", 32'(n), 9);
    @(negedge clk);
    chk_eq("t6_idle_penable", 32'(M_PENABLE), 0);
    chk_eq("t6_idle_psel",    32'(M_PSEL), 0);
    wait_idle();
    delay[2] = 0;
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
